mano_seq_ctrl: RTL and testbench

- Parametrised multicycle sequencer for the basic accumulator CPU; successor to the single-step control unit.
- Owns PC, IR and AR, and runs fetch, decode, indirect and execute phases.
- Talks to memory over a req/ack handshake with variable latency, and drives one-cycle micro-op strobes to the AC/DR/E datapath.
- Adds over the previous control unit: full 7-op memory-reference set (AND, ADD, LDA, STA, BUN, BSA, ISZ), skip instructions, HLT, and wait-state memory.

---
 rtl/mano_pkg.sv | 42 ++++
 rtl/mano_seq_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mano_seq_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mano_pkg.sv
// rtl/mano_pkg.sv - shared types and constants for the accumulator CPU sequencer
package mano_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        INDIRECT = 4'd3,
        EXEC0    = 4'd4,
        EXEC1    = 4'd5,
        EXEC2    = 4'd6,
        RREF     = 4'd7,
        HALT     = 4'd8
    } state_t;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_LDA  = 3'd2;
    localparam logic [2:0] OP_STA  = 3'd3;
    localparam logic [2:0] OP_BUN  = 3'd4;
    localparam logic [2:0] OP_BSA  = 3'd5;
    localparam logic [2:0] OP_ISZ  = 3'd6;
    localparam logic [2:0] OP_RREF = 3'd7;

    localparam int RR_CLA = 11;
    localparam int RR_CLE = 10;
    localparam int RR_CMA = 9;
    localparam int RR_CME = 8;
    localparam int RR_CIR = 7;
    localparam int RR_CIL = 6;
    localparam int RR_INC = 5;
    localparam int RR_SPA = 4;
    localparam int RR_SNA = 3;
    localparam int RR_SZA = 2;
    localparam int RR_SZE = 1;
    localparam int RR_HLT = 0;

    localparam logic [1:0] WSEL_AC = 2'd0;
    localparam logic [1:0] WSEL_DR = 2'd1;
    localparam logic [1:0] WSEL_PC = 2'd2;

endpackage

// File: rtl/mano_seq_ctrl.sv
// rtl/mano_seq_ctrl.sv - multicycle fetch/decode/indirect/execute sequencer
module mano_seq_ctrl
    import mano_pkg::*;
#(
    parameter int                DWIDTH   = 16,
    parameter int                AWIDTH   = 12,
    parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [AWIDTH-1:0] o_mem_addr,
    output logic [1:0]        o_wsel,
    input  logic              i_mem_ack,
    input  logic [DWIDTH-1:0] i_mem_rdata,
    output logic              o_dr_load,
    output logic              o_dr_inc,
    output logic              o_ac_and,
    output logic              o_ac_add,
    output logic              o_ac_lda,
    output logic              o_rr_valid,
    output logic [11:0]       o_rr_op,
    input  logic              i_ac_zero,
    input  logic              i_ac_neg,
    input  logic              i_e,
    input  logic              i_dr_zero,
    output logic [AWIDTH-1:0] o_pc,
    output logic [DWIDTH-1:0] o_ir,
    output logic              o_busy,
    output logic              o_halted
);

    localparam logic [AWIDTH-1:0] ADDR_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nxt;
    logic [AWIDTH-1:0] pc;
    logic [AWIDTH-1:0] ar;
    logic [DWIDTH-1:0] ir;
    logic              ind_bit;
    logic [2:0]        opc;
    logic              mem_done;
    logic              skip;

    assign ind_bit  = ir[DWIDTH-1];
    assign opc      = ir[DWIDTH-2:DWIDTH-4];
    // An ack only counts while a request is outstanding
    assign mem_done = o_mem_req & i_mem_ack;
    assign o_pc     = pc;
    assign o_ir     = ir;
    assign o_rr_op  = ir[11:0];

    // Skip condition uses the flags as they stand before the datapath acts on this RREF
    always_comb begin
        skip = (ir[RR_SPA] & ~i_ac_neg) |
               (ir[RR_SNA] &  i_ac_neg) |
               (ir[RR_SZA] &  i_ac_zero) |
               (ir[RR_SZE] & ~i_e);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (i_start) state_nxt = FETCH;
            FETCH:    if (mem_done) state_nxt = DECODE;
            DECODE: begin
                if (opc == OP_RREF) begin
                    state_nxt = ind_bit ? FETCH : RREF;
                end else if (ind_bit) begin
                    state_nxt = INDIRECT;
                end else begin
                    state_nxt = EXEC0;
                end
            end
            INDIRECT: if (mem_done) state_nxt = EXEC0;
            EXEC0: begin
                case (opc)
                    OP_AND, OP_ADD, OP_LDA, OP_ISZ: if (mem_done) state_nxt = EXEC1;
                    OP_STA, OP_BSA:                 if (mem_done) state_nxt = FETCH;
                    default:                        state_nxt = FETCH;
                endcase
            end
            EXEC1:    state_nxt = (opc == OP_ISZ) ? EXEC2 : FETCH;
            EXEC2:    if (mem_done) state_nxt = FETCH;
            RREF:     state_nxt = ir[RR_HLT] ? HALT : FETCH;
            HALT:     if (i_start) state_nxt = FETCH;
            default:  state_nxt = IDLE;
        endcase
    end

    // Memory request and micro-op strobes decoded from the current state and IR
    always_comb begin
        o_mem_req  = 1'b0;
        o_mem_we   = 1'b0;
        o_mem_addr = ar;
        o_wsel     = WSEL_AC;
        o_dr_load  = 1'b0;
        o_dr_inc   = 1'b0;
        o_ac_and   = 1'b0;
        o_ac_add   = 1'b0;
        o_ac_lda   = 1'b0;
        o_rr_valid = 1'b0;
        case (state)
            FETCH: begin
                o_mem_req  = 1'b1;
                o_mem_addr = pc;
            end
            INDIRECT: o_mem_req = 1'b1;
            EXEC0: begin
                case (opc)
                    OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                        o_mem_req = 1'b1;
                        o_dr_load = i_mem_ack;
                    end
                    OP_STA: begin
                        o_mem_req = 1'b1;
                        o_mem_we  = 1'b1;
                        o_wsel    = WSEL_AC;
                    end
                    OP_BSA: begin
                        o_mem_req = 1'b1;
                        o_mem_we  = 1'b1;
                        o_wsel    = WSEL_PC;
                    end
                    default: ;
                endcase
            end
            EXEC1: begin
                case (opc)
                    OP_AND:  o_ac_and = 1'b1;
                    OP_ADD:  o_ac_add = 1'b1;
                    OP_LDA:  o_ac_lda = 1'b1;
                    OP_ISZ:  o_dr_inc = 1'b1;
                    default: ;
                endcase
            end
            EXEC2: begin
                o_mem_req = 1'b1;
                o_mem_we  = 1'b1;
                o_wsel    = WSEL_DR;
            end
            RREF:    o_rr_valid = 1'b1;
            default: ;
        endcase
    end

    assign o_busy   = (state != IDLE) && (state != HALT);
    assign o_halted = (state == HALT);

    // PC, IR and AR updates at the completion points of each phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
            ir <= '0;
            ar <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_done) begin
                        ir <= i_mem_rdata;
                        pc <= pc + ADDR_ONE;
                    end
                end
                DECODE:   ar <= ir[AWIDTH-1:0];
                INDIRECT: if (mem_done) ar <= i_mem_rdata[AWIDTH-1:0];
                EXEC0: begin
                    if (opc == OP_BUN) begin
                        pc <= ar;
                    end else if (opc == OP_BSA && mem_done) begin
                        pc <= ar + ADDR_ONE;
                    end
                end
                EXEC2:    if (mem_done && i_dr_zero) pc <= pc + ADDR_ONE;
                RREF:     if (skip) pc <= pc + ADDR_ONE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mano_seq_ctrl.sv
// tb/tb_mano_seq_ctrl.sv - scoreboard bench for mano_seq_ctrl
module tb_mano_seq_ctrl;
    import mano_pkg::*;

    localparam int K_MEM = 1;
    localparam int K_DRL = 2;
    localparam int K_AND = 3;
    localparam int K_ADD = 4;
    localparam int K_LDA = 5;
    localparam int K_INC = 6;
    localparam int K_RR  = 7;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_start = 1'b0;
    logic        o_mem_req, o_mem_we;
    logic [11:0] o_mem_addr;
    logic [1:0]  o_wsel;
    logic        i_mem_ack;
    logic [15:0] i_mem_rdata;
    logic        o_dr_load, o_dr_inc, o_ac_and, o_ac_add, o_ac_lda, o_rr_valid;
    logic [11:0] o_rr_op;
    logic        i_ac_zero = 1'b1;
    logic        i_ac_neg = 1'b0;
    logic        i_e = 1'b1;
    logic        i_dr_zero = 1'b1;
    logic [11:0] o_pc;
    logic [15:0] o_ir;
    logic        o_busy, o_halted;

    logic [15:0] mem [0:4095];
    int          lat = 0;
    int          wcnt = 0;
    logic        spur = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [47:0] exp_q[$];
    logic        prev_pending = 1'b0;
    logic [14:0] held = '0;

    mano_seq_ctrl #(.DWIDTH(16), .AWIDTH(12), .RESET_PC(12'h010)) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_wsel(o_wsel),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .o_dr_load(o_dr_load), .o_dr_inc(o_dr_inc), .o_ac_and(o_ac_and),
        .o_ac_add(o_ac_add), .o_ac_lda(o_ac_lda),
        .o_rr_valid(o_rr_valid), .o_rr_op(o_rr_op),
        .i_ac_zero(i_ac_zero), .i_ac_neg(i_ac_neg), .i_e(i_e), .i_dr_zero(i_dr_zero),
        .o_pc(o_pc), .o_ir(o_ir), .o_busy(o_busy), .o_halted(o_halted)
    );

    always #5 clk = ~clk;

    // Variable-latency memory: ack after lat wait cycles, spur injects stray acks
    assign i_mem_ack   = (o_mem_req && (wcnt >= lat)) || spur;
    assign i_mem_rdata = mem[o_mem_addr];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) wcnt <= 0;
        else if (o_mem_req && !i_mem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] ev(input int kind, input logic we, input logic [1:0] ws,
                                       input logic [11:0] a, input logic [15:0] d);
        return {kind[7:0], 3'b0, we, 2'b0, ws, 4'b0, a, d};
    endfunction

    task automatic observe(input logic [47:0] e);
        if (exp_q.size() == 0) chk("unexpected_event", e, 48'h0);
        else chk("event", e, exp_q.pop_front());
    endtask

    task automatic exp_rd(input logic [11:0] a, input logic [15:0] d);
        exp_q.push_back(ev(K_MEM, 1'b0, 2'd0, a, d));
    endtask

    task automatic exp_wr(input logic [1:0] ws, input logic [11:0] a, input logic [15:0] d);
        exp_q.push_back(ev(K_MEM, 1'b1, ws, a, d));
    endtask

    task automatic exp_k(input int k, input logic [11:0] op);
        exp_q.push_back(ev(k, 1'b0, 2'd0, 12'h0, {4'h0, op}));
    endtask

    // Monitor: turn completed accesses and strobes into events, check request stability
    always @(negedge clk) begin
        if (reset_n) begin
            if (o_mem_req && prev_pending)
                chk("req_hold", {32'h0, 1'b1, o_mem_we, o_wsel, o_mem_addr}, {32'h0, 1'b1, held});
            if (o_mem_req && i_mem_ack)
                observe(ev(K_MEM, o_mem_we, o_mem_we ? o_wsel : 2'd0, o_mem_addr,
                           o_mem_we ? ((o_wsel == WSEL_PC) ? {4'h0, o_pc} : 16'h0) : i_mem_rdata));
            if (o_dr_load)  observe(ev(K_DRL, 1'b0, 2'd0, 12'h0, 16'h0));
            if (o_dr_inc)   observe(ev(K_INC, 1'b0, 2'd0, 12'h0, 16'h0));
            if (o_ac_and)   observe(ev(K_AND, 1'b0, 2'd0, 12'h0, 16'h0));
            if (o_ac_add)   observe(ev(K_ADD, 1'b0, 2'd0, 12'h0, 16'h0));
            if (o_ac_lda)   observe(ev(K_LDA, 1'b0, 2'd0, 12'h0, 16'h0));
            if (o_rr_valid) observe(ev(K_RR, 1'b0, 2'd0, 12'h0, {4'h0, o_rr_op}));
            prev_pending = o_mem_req && !i_mem_ack;
            held = {o_mem_we, o_wsel, o_mem_addr};
        end else begin
            prev_pending = 1'b0;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
    endtask

    task automatic wait_halt();
        int n = 0;
        while (!o_halted && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("halt_reached", {47'h0, o_halted}, 48'h1);
    endtask

    task automatic check_parked(input string tag, input logic [11:0] pc_exp);
        spur = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk({tag, "_noreq"}, {47'h0, o_mem_req}, 48'h0);
        end
        spur = 1'b0;
        chk({tag, "_pc"}, {36'h0, o_pc}, {36'h0, pc_exp});
        chk({tag, "_q_empty"}, 48'(exp_q.size()), 48'h0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
        mem[12'h010] = 16'h2100; mem[12'h011] = 16'h4020;
        mem[12'h020] = 16'h5050; mem[12'h051] = 16'h6060;
        mem[12'h053] = 16'h7004; mem[12'h055] = 16'h7001;
        mem[12'h056] = 16'h9200; mem[12'h057] = 16'h3070;
        mem[12'h058] = 16'h0100; mem[12'h059] = 16'h7010;
        mem[12'h05B] = 16'h7008; mem[12'h05C] = 16'hF800;
        mem[12'h05D] = 16'h7001; mem[12'h05E] = 16'h7001;
        mem[12'h100] = 16'h1234; mem[12'h200] = 16'h0300;
        mem[12'h300] = 16'h0005; mem[12'h060] = 16'hFFFF;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req", {45'h0, o_mem_req, o_mem_we, o_busy}, 48'h0);
        chk("rst_pc_ir", {16'h0, o_pc, 4'h0, o_ir}, {16'h0, 12'h010, 4'h0, 16'h0});
        chk("rst_strobes", {40'h0, o_dr_load, o_dr_inc, o_ac_and, o_ac_add, o_ac_lda, o_rr_valid, o_wsel},
            48'h0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        chk("idle_flags", {46'h0, o_busy, o_halted}, 48'h0);

        // Zero-wait run: LDA, BUN, BSA, ISZ with skip, SZA skip, HLT
        lat = 0;
        exp_rd(12'h010, 16'h2100); exp_rd(12'h100, 16'h1234); exp_k(K_DRL, 0); exp_k(K_LDA, 0);
        exp_rd(12'h011, 16'h4020);
        exp_rd(12'h020, 16'h5050); exp_wr(WSEL_PC, 12'h050, 16'h0021);
        exp_rd(12'h051, 16'h6060); exp_rd(12'h060, 16'hFFFF); exp_k(K_DRL, 0); exp_k(K_INC, 0);
        exp_wr(WSEL_DR, 12'h060, 16'h0000);
        exp_rd(12'h053, 16'h7004); exp_k(K_RR, 12'h004);
        exp_rd(12'h055, 16'h7001); exp_k(K_RR, 12'h001);
        pulse_start();
        wait_halt();
        check_parked("seg1", 12'h056);

        // Three-wait run: indirect ADD, STA, AND, SPA skip, SNA no skip, I/O NOP, HLT
        lat = 3;
        exp_rd(12'h056, 16'h9200); exp_rd(12'h200, 16'h0300); exp_rd(12'h300, 16'h0005);
        exp_k(K_DRL, 0); exp_k(K_ADD, 0);
        exp_rd(12'h057, 16'h3070); exp_wr(WSEL_AC, 12'h070, 16'h0000);
        exp_rd(12'h058, 16'h0100); exp_rd(12'h100, 16'h1234); exp_k(K_DRL, 0); exp_k(K_AND, 0);
        exp_rd(12'h059, 16'h7010); exp_k(K_RR, 12'h010);
        exp_rd(12'h05B, 16'h7008); exp_k(K_RR, 12'h008);
        exp_rd(12'h05C, 16'hF800);
        exp_rd(12'h05D, 16'h7001); exp_k(K_RR, 12'h001);
        pulse_start();
        wait_halt();
        check_parked("seg2", 12'h05E);

        // Reset while a slow fetch is pending
        lat = 10;
        pulse_start();
        repeat (3) @(negedge clk);
        chk("pend_req", {47'h0, o_mem_req}, 48'h1);
        @(posedge clk); #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_req", {46'h0, o_mem_req, o_busy}, 48'h0);
        chk("mid_rst_pc", {36'h0, o_pc}, 48'h010);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        check_parked("post_rst", 12'h010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
